// File: rtl/vliw_regfile_mp.sv
// rtl/vliw_regfile_mp.sv - multi-ported VLIW register file with busy scoreboard
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module vliw_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_WR-1:0]          iss_en,
    input  logic [NUM_WR*ADDR_W-1:0]   iss_addr,
    output logic                       wr_conflict
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic                r_wr_conflict;

    logic [NUM_WR-1:0]   w_wr_ok;
    logic [NUM_WR-1:0]   w_iss_ok;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic                w_conflict;

    // With ZERO_REG, anything aimed at r0 is dropped before it reaches state or collision logic.
    always_comb begin
        w_wr_ok  = '0;
        w_iss_ok = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            w_wr_ok[w]  = wr_en[w]  && !((ZERO_REG != 0) && (wr_addr[w*ADDR_W +: ADDR_W] == '0));
            w_iss_ok[w] = iss_en[w] && !((ZERO_REG != 0) && (iss_addr[w*ADDR_W +: ADDR_W] == '0));
        end
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (w_iss_ok[w]) w_set[iss_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
            if (w_wr_ok[w])  w_clr[wr_addr[w*ADDR_W +: ADDR_W]]  = 1'b1;
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (w_wr_ok[i] && w_wr_ok[j] &&
                    (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]))
                    w_conflict = 1'b1;
            end
        end
    end

    // Later ports overwrite earlier ones in the loop, so the highest index wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
            r_busy        <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_wr_ok[w]) r_regs[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
            end
            r_busy        <= w_set | (r_busy & ~w_clr);
            r_wr_conflict <= w_conflict;
        end
    end

    assign wr_conflict = r_wr_conflict;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_ra = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = r_regs[w_ra];
            w_busy = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_wr_ok[w] && (wr_addr[w*ADDR_W +: ADDR_W] == w_ra))
                    w_data = wr_data[w*DATA_W +: DATA_W];
            end
            if (w_clr[w_ra] && !w_set[w_ra]) w_busy = 1'b0;
`endif
            if (!rst_n || ((ZERO_REG != 0) && (w_ra == '0))) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = w_data;
        assign rd_busy[p]                  = w_busy;
    end

endmodule

// File: tb/tb_vliw_regfile_mp.sv
// tb/tb_vliw_regfile_mp.sv - directed self-checking bench for vliw_regfile_mp
module tb_vliw_regfile_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: 32-bit, 32 regs, 4R/2W
    logic [19:0]  rd_addr = '0;
    logic [127:0] rd_data;
    logic [3:0]   rd_busy;
    logic [1:0]   wr_en = '0;
    logic [9:0]   wr_addr = '0;
    logic [63:0]  wr_data = '0;
    logic [1:0]   iss_en = '0;
    logic [9:0]   iss_addr = '0;
    logic         wr_conflict;

    // Wide configuration: 64-bit, 64 regs, 6R/3W
    logic [35:0]  b_rd_addr = '0;
    logic [383:0] b_rd_data;
    logic [5:0]   b_rd_busy;
    logic [2:0]   b_wr_en = '0;
    logic [17:0]  b_wr_addr = '0;
    logic [191:0] b_wr_data = '0;
    logic [2:0]   b_iss_en = '0;
    logic [17:0]  b_iss_addr = '0;
    logic         b_wr_conflict;

    vliw_regfile_mp u_dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .wr_conflict(wr_conflict)
    );

    vliw_regfile_mp #(.DATA_W(64), .NUM_REGS(64), .NUM_RD(6), .NUM_WR(3)) u_dut_wide (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(b_iss_en), .iss_addr(b_iss_addr), .wr_conflict(b_wr_conflict)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; iss_en = '0; b_wr_en = '0; b_iss_en = '0;
    endtask

    initial begin
        #1;
        check("reset_rd_data", {32'h0, rd_data[31:0]}, 64'h0);
        check("reset_rd_busy", {60'h0, rd_busy}, 64'h0);
        check("reset_conflict", {63'h0, wr_conflict}, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Write/read r5
        rd_addr = {5'd5, 5'd5, 5'd5, 5'd5};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("wr_same_cycle", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
`else
        check("wr_same_cycle", {32'h0, rd_data[31:0]}, 64'h0);
`endif
        tick(); idle(); #1;
        for (int p = 0; p < 4; p++) check($sformatf("wr_next_p%0d", p), {32'h0, rd_data[p*32 +: 32]}, 64'hDEADBEEF);
        check("wr_no_conflict", {63'h0, wr_conflict}, 64'h0);

        // Collision on r7
        rd_addr = {5'd7, 5'd5, 5'd5, 5'd5};
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        tick(); idle(); #1;
        check("coll_data", {32'h0, rd_data[96 +: 32]}, 64'h22);
        check("coll_pulse", {63'h0, wr_conflict}, 64'h1);
        tick();
        check("coll_pulse_end", {63'h0, wr_conflict}, 64'h0);

        // Scoreboard on r9
        rd_addr = {5'd5, 5'd5, 5'd9, 5'd5};
        iss_en = 2'b01; iss_addr = {5'd0, 5'd9};
        #1;
        check("sb_pre_busy", {63'h0, rd_busy[1]}, 64'h0);
        tick(); idle(); #1;
        check("sb_set", {63'h0, rd_busy[1]}, 64'h1);
        check("sb_other_idle", {63'h0, rd_busy[0]}, 64'h0);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
        iss_en = 2'b10; iss_addr = {5'd9, 5'd0};
        #1;
        check("sb_setclr_same", {63'h0, rd_busy[1]}, 64'h1);
        tick(); idle(); #1;
        check("sb_set_wins", {63'h0, rd_busy[1]}, 64'h1);
        check("sb_data", {32'h0, rd_data[32 +: 32]}, 64'h99);
        wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'hAA, 32'h0};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("sb_clr_same", {63'h0, rd_busy[1]}, 64'h0);
`else
        check("sb_clr_same", {63'h0, rd_busy[1]}, 64'h1);
`endif
        tick(); idle(); #1;
        check("sb_clr", {63'h0, rd_busy[1]}, 64'h0);
        check("sb_clr_data", {32'h0, rd_data[32 +: 32]}, 64'hAA);

        // Zero register
        rd_addr = {5'd0, 5'd0, 5'd0, 5'd0};
        wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
        iss_en = 2'b01; iss_addr = {5'd0, 5'd0};
        #1;
        check("r0_same_data", {32'h0, rd_data[31:0]}, 64'h0);
        check("r0_same_busy", {63'h0, rd_busy[0]}, 64'h0);
        tick(); idle(); #1;
        check("r0_data", {32'h0, rd_data[127 -: 32]}, 64'h0);
        check("r0_busy", {60'h0, rd_busy}, 64'h0);
        check("r0_conflict", {63'h0, wr_conflict}, 64'h0);

        // Mid-run reset with live busy bit and conflict pulse
        rd_addr = {5'd12, 5'd3, 5'd7, 5'd5};
        iss_en = 2'b01; iss_addr = {5'd0, 5'd3};
        wr_en = 2'b11; wr_addr = {5'd12, 5'd12}; wr_data = {32'h5A5A5A5A, 32'h1};
        tick(); idle(); #1;
        check("pre_rst_conflict", {63'h0, wr_conflict}, 64'h1);
        check("pre_rst_busy", {63'h0, rd_busy[2]}, 64'h1);
        check("pre_rst_r12", {32'h0, rd_data[96 +: 32]}, 64'h5A5A5A5A);
        #1 rst_n = 1'b0;
        #1;
        check("rst_rd_data", {rd_data[127:64] | rd_data[63:0]}, 64'h0);
        check("rst_rd_busy", {60'h0, rd_busy}, 64'h0);
        check("rst_conflict", {63'h0, wr_conflict}, 64'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_r5", {32'h0, rd_data[31:0]}, 64'h0);

        // Wide configuration, highest-index ports
        b_wr_en = 3'b100; b_wr_addr = {6'd63, 6'd0, 6'd0};
        b_wr_data = {64'hDEADBEEF_CAFEF00D, 64'h0, 64'h0};
        b_rd_addr = {6'd63, 30'h0};
        tick(); idle(); #1;
        check("w_wr_p5", b_rd_data[320 +: 64], 64'hDEADBEEF_CAFEF00D);
        check("w_wr_p0", b_rd_data[63:0], 64'h0);
        b_wr_en = 3'b110; b_wr_addr = {6'd40, 6'd40, 6'd0};
        b_wr_data = {64'hBBBB_0000_0000_BBBB, 64'hAAAA_0000_0000_AAAA, 64'h0};
        b_rd_addr = {6'd40, 6'd63, 24'h0};
        tick(); idle(); #1;
        check("w_coll_data", b_rd_data[320 +: 64], 64'hBBBB_0000_0000_BBBB);
        check("w_coll_p4", b_rd_data[256 +: 64], 64'hDEADBEEF_CAFEF00D);
        check("w_coll_pulse", {63'h0, b_wr_conflict}, 64'h1);
        tick();
        check("w_coll_end", {63'h0, b_wr_conflict}, 64'h0);
        b_rd_addr = {6'd50, 30'h0};
        b_iss_en = 3'b100; b_iss_addr = {6'd50, 6'd0, 6'd0};
        tick(); idle(); #1;
        check("w_sb_set", {63'h0, b_rd_busy[5]}, 64'h1);
        b_wr_en = 3'b100; b_wr_addr = {6'd50, 6'd0, 6'd0}; b_wr_data = {64'h1234, 128'h0};
        b_iss_en = 3'b001; b_iss_addr = {6'd0, 6'd0, 6'd50};
        tick(); idle(); #1;
        check("w_sb_set_wins", {63'h0, b_rd_busy[5]}, 64'h1);
        b_wr_en = 3'b100; b_wr_addr = {6'd50, 6'd0, 6'd0};
        tick(); idle(); #1;
        check("w_sb_clr", {63'h0, b_rd_busy[5]}, 64'h0);
        check("w_sb_data", b_rd_data[320 +: 64], 64'h1234);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
